// File: rtl/fp_normalize_ctrl.sv
// Floating-point result normalization controller.
// Normalizes an unnormalized exponent/mantissa pair one bit per cycle,
// using an external exponent increment/decrement unit for every step.
// Optional feature: define FPNORM_UNDERFLOW_FLAG_EN to add the underflow
// output, which flags results that end up denormal.
module fp_normalize_ctrl #(
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        exp_in,
    input  logic [FRAC_W+1:0] mant_in,
    input  logic [7:0]        incdec_result,
    output logic              busy,
    output logic              done,
    output logic [7:0]        exp_out,
    output logic [FRAC_W:0]   mant_out,
    output logic              overflow,
`ifdef FPNORM_UNDERFLOW_FLAG_EN
    output logic              underflow,
`endif
    output logic [7:0]        incdec_exp,
    output logic [3:0]        incdec_aluop,
    output logic              incdec_enable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT_R,
        S_SHIFT_L,
        S_DONE
    } state_t;

    localparam logic [3:0] ALU_INC = 4'b0000;
    localparam logic [3:0] ALU_DEC = 4'b0011;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_exp;
    logic [FRAC_W+1:0]   r_mant;
    logic [7:0]          w_exp_nxt;
    logic [FRAC_W+1:0]   w_mant_nxt;
    logic                w_ovf_nxt;
    logic                w_enter_done;
    logic                w_denorm;
    logic [7:0]          r_exp_out;
    logic [FRAC_W:0]     r_mant_out;
    logic                r_ovf;
`ifdef FPNORM_UNDERFLOW_FLAG_EN
    logic                r_uf;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus next value of the working exponent/mantissa
    always_comb begin
        w_next     = r_state;
        w_exp_nxt  = r_exp;
        w_mant_nxt = r_mant;
        w_ovf_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_CHECK;
                    w_exp_nxt  = exp_in;
                    w_mant_nxt = mant_in;
                end
            end
            S_CHECK: begin
                if (r_exp == 8'hFF) begin
                    w_next = S_DONE;
                end else if (r_mant == '0) begin
                    w_next    = S_DONE;
                    w_exp_nxt = '0;
                end else if (r_mant[FRAC_W+1]) begin
                    w_next = S_SHIFT_R;
                end else if (r_mant[FRAC_W]) begin
                    w_next = S_DONE;
                end else if (r_exp <= 8'd1) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SHIFT_L;
                end
            end
            S_SHIFT_R: begin
                w_next    = S_DONE;
                w_exp_nxt = incdec_result;
                if (incdec_result == 8'hFF) begin
                    w_mant_nxt = '0;
                    w_ovf_nxt  = 1'b1;
                end else begin
                    w_mant_nxt = {1'b0, r_mant[FRAC_W+1:1]};
                end
            end
            S_SHIFT_L: begin
                w_exp_nxt  = incdec_result;
                w_mant_nxt = {r_mant[FRAC_W:0], 1'b0};
                if (r_mant[FRAC_W-1] || (incdec_result == 8'd1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Results are captured on the edge into DONE so they are visible while done=1.
    // An all-ones exponent (pass-through or overflow) is never treated as denormal.
    assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
    assign w_denorm     = (w_exp_nxt != 8'hFF) && !w_mant_nxt[FRAC_W] && (w_mant_nxt != '0);

    // Working registers and held result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp      <= '0;
            r_mant     <= '0;
            r_exp_out  <= '0;
            r_mant_out <= '0;
            r_ovf      <= 1'b0;
`ifdef FPNORM_UNDERFLOW_FLAG_EN
            r_uf       <= 1'b0;
`endif
        end else begin
            r_exp  <= w_exp_nxt;
            r_mant <= w_mant_nxt;
            if (w_enter_done) begin
                r_exp_out  <= w_denorm ? '0 : w_exp_nxt;
                r_mant_out <= w_mant_nxt[FRAC_W:0];
                r_ovf      <= w_ovf_nxt;
`ifdef FPNORM_UNDERFLOW_FLAG_EN
                r_uf       <= w_denorm;
`endif
            end
        end
    end

    // State-decoded outputs and inc/dec unit control
    always_comb begin
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        incdec_enable = 1'b0;
        incdec_aluop  = ALU_INC;
        case (r_state)
            S_SHIFT_R: begin
                incdec_enable = 1'b1;
                incdec_aluop  = ALU_INC;
            end
            S_SHIFT_L: begin
                incdec_enable = 1'b1;
                incdec_aluop  = ALU_DEC;
            end
            default: begin
                incdec_enable = 1'b0;
                incdec_aluop  = ALU_INC;
            end
        endcase
    end

    assign incdec_exp = r_exp;
    assign exp_out    = r_exp_out;
    assign mant_out   = r_mant_out;
    assign overflow   = r_ovf;
`ifdef FPNORM_UNDERFLOW_FLAG_EN
    assign underflow  = r_uf;
`endif

endmodule

// File: tb/tb_fp_normalize_ctrl.sv
// Self-checking bench for fp_normalize_ctrl with a behavioural
// normalization model and an inc/dec unit model.
`timescale 1ns/1ps
module tb_fp_normalize_ctrl;

    localparam int FRAC_W = 23;
    localparam int MW     = FRAC_W + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        exp_in;
    logic [MW-1:0]     mant_in;
    logic [7:0]        incdec_result;
    logic              busy;
    logic              done;
    logic [7:0]        exp_out;
    logic [FRAC_W:0]   mant_out;
    logic              overflow;
`ifdef FPNORM_UNDERFLOW_FLAG_EN
    logic              underflow;
`endif
    logic [7:0]        incdec_exp;
    logic [3:0]        incdec_aluop;
    logic              incdec_enable;

    int checks   = 0;
    int failures = 0;

    fp_normalize_ctrl #(.FRAC_W(FRAC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .exp_in        (exp_in),
        .mant_in       (mant_in),
        .incdec_result (incdec_result),
        .busy          (busy),
        .done          (done),
        .exp_out       (exp_out),
        .mant_out      (mant_out),
        .overflow      (overflow),
`ifdef FPNORM_UNDERFLOW_FLAG_EN
        .underflow     (underflow),
`endif
        .incdec_exp    (incdec_exp),
        .incdec_aluop  (incdec_aluop),
        .incdec_enable (incdec_enable)
    );

    always #5 clk = ~clk;

    // Exponent increment/decrement unit
    always_comb begin
        case (incdec_aluop)
            4'b0000: incdec_result = incdec_exp + 8'd1;
            4'b0011: incdec_result = incdec_exp - 8'd1;
            default: incdec_result = incdec_exp;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Behavioural normalization: leading-zero count and exponent arithmetic
    function automatic void ref_norm(input logic [7:0] e, input logic [MW-1:0] m,
                                     output logic [7:0] eo, output logic [FRAC_W:0] mo,
                                     output logic ov, output logic uf,
                                     output int n, output logic up);
        int lz;
        ov = 1'b0; uf = 1'b0; n = 0; up = 1'b0;
        eo = e; mo = m[FRAC_W:0];
        if (e == 8'hFF) begin
            eo = e;
            mo = m[FRAC_W:0];
        end else if (m == '0) begin
            eo = 8'h00;
            mo = '0;
        end else if (m[FRAC_W+1]) begin
            n = 1; up = 1'b1;
            if (e == 8'hFE) begin
                eo = 8'hFF; mo = '0; ov = 1'b1;
            end else begin
                eo = 8'(int'(e) + 1);
                mo = m[FRAC_W+1:1];
            end
        end else if (m[FRAC_W]) begin
            eo = e;
            mo = m[FRAC_W:0];
        end else begin
            lz = 0;
            while (!m[FRAC_W-lz]) lz++;
            if (e <= 8'd1) n = 0;
            else if (lz < int'(e) - 1) n = lz;
            else n = int'(e) - 1;
            mo = m[FRAC_W:0] << n;
            eo = 8'(int'(e) - n);
            if (!mo[FRAC_W]) begin
                eo = 8'h00; uf = 1'b1;
            end
        end
    endfunction

    task automatic run_op(input logic [7:0] e, input logic [MW-1:0] m, input string tag);
        logic [7:0]      eo;
        logic [FRAC_W:0] mo;
        logic            ov, uf, up;
        int              n, lat, n_en;
        bit              bad_op, busy_bad;
        ref_norm(e, m, eo, mo, ov, uf, n, up);
        @(negedge clk);
        exp_in = e; mant_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; n_en = 0; bad_op = 0; busy_bad = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1;
            if (incdec_enable === 1'b1) begin
                n_en++;
                if (incdec_aluop !== (up ? 4'b0000 : 4'b0011)) bad_op = 1;
            end else if (incdec_aluop !== 4'b0000) begin
                bad_op = 1;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 2 + n) begin
            failures++;
            $display("FAIL %s latency: e=%h m=%h got %0d expected %0d", tag, e, m, lat, 2 + n);
        end
        checks++;
        if (n_en !== n) begin
            failures++;
            $display("FAIL %s enable_count: got %0d expected %0d", tag, n_en, n);
        end
        checks++;
        if (bad_op || busy_bad) begin
            failures++;
            $display("FAIL %s aluop_busy: bad_aluop=%0d busy_low=%0d expected 0 0", tag, bad_op, busy_bad);
        end
        checks++;
        if (exp_out !== eo || mant_out !== mo || overflow !== ov) begin
            failures++;
            $display("FAIL %s result: e=%h m=%h got exp=%h mant=%h ovf=%b expected exp=%h mant=%h ovf=%b",
                     tag, e, m, exp_out, mant_out, overflow, eo, mo, ov);
        end
`ifdef FPNORM_UNDERFLOW_FLAG_EN
        checks++;
        if (underflow !== uf) begin
            failures++;
            $display("FAIL %s underflow: got %b expected %b", tag, underflow, uf);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_out !== eo || mant_out !== mo) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b exp=%h mant=%h expected 0 0 %h %h",
                     tag, done, busy, exp_out, mant_out, eo, mo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; exp_in = '0; mant_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || exp_out !== 8'h00 || mant_out !== '0 || overflow !== 1'b0 ||
            incdec_enable !== 1'b0 || incdec_exp !== 8'h00 || incdec_aluop !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b exp=%h mant=%h ovf=%b en=%b iexp=%h op=%h expected all 0",
                     busy, done, exp_out, mant_out, overflow, incdec_enable, incdec_exp, incdec_aluop);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(8'h80, 25'h0800000, "hidden_set");
        run_op(8'h80, 25'h1000000, "carry_set");
        run_op(8'h80, 25'h0000001, "shift_left_23");
        run_op(8'hFE, 25'h1000000, "overflow");
        run_op(8'h03, 25'h0000001, "denormal");
        run_op(8'h01, 25'h0400000, "exp_one");
        run_op(8'h55, 25'h0000000, "zero_mant");
        run_op(8'hFF, 25'h0812345, "pass_through");
        run_op(8'h02, 25'h0400000, "shift_to_exp1");
    endtask

    task automatic test_random();
        logic [7:0]    e;
        logic [MW-1:0] m, mask;
        int            k;
        for (int i = 0; i < 40; i++) begin
            e = 8'($urandom_range(0, 254));
            if (($urandom % 8) == 0) e = 8'hFE;
            case ($urandom_range(0, 3))
                0: m = MW'($urandom) | (MW'(1) << (FRAC_W + 1));
                1: m = (MW'($urandom) & ~(MW'(1) << (FRAC_W + 1))) | (MW'(1) << FRAC_W);
                2: begin
                    k    = $urandom_range(1, FRAC_W);
                    mask = (MW'(1) << k) - MW'(1);
                    m    = MW'($urandom) & mask;
                    if (m == '0) m = MW'(1);
                end
                default: m = '0;
            endcase
            run_op(e, m, "random");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        exp_in = 8'h40; mant_in = 25'h0812345; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got %b expected 1", done);
        end
        exp_in = 8'h22; mant_in = 25'h0000003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start_in_done: busy=%b done=%b expected 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_out !== 8'h40 || mant_out !== 24'h812345 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold: exp=%h mant=%h busy=%b expected 40 812345 0", exp_out, mant_out, busy);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        exp_in = 8'h80; mant_in = 25'h0000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 5) begin
                exp_in = 8'h10; mant_in = 25'h0812345; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 25 || exp_out !== 8'h69 || mant_out !== 24'h800000) begin
            failures++;
            $display("FAIL busy_ignore: lat=%0d exp=%h mant=%h expected 25 69 800000", lat, exp_out, mant_out);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        exp_in = 8'h80; mant_in = 25'h0000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        exp_in = 8'h33; mant_in = 25'h0800001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || incdec_enable !== 1'b1 || incdec_aluop !== 4'b0011) begin
            failures++;
            $display("FAIL abort_in_shift: busy=%b en=%b op=%h expected 1 1 3", busy, incdec_enable, incdec_aluop);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || exp_out !== 8'h00 || mant_out !== '0 || overflow !== 1'b0 ||
            incdec_enable !== 1'b0 || incdec_exp !== 8'h00 || incdec_aluop !== 4'b0000) begin
            failures++;
            $display("FAIL abort_reset_state: busy=%b done=%b exp=%h mant=%h ovf=%b en=%b iexp=%h op=%h expected all 0",
                     busy, done, exp_out, mant_out, overflow, incdec_enable, incdec_exp, incdec_aluop);
        end
        saw_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_no_done: activity after reset got 1 expected 0");
        end
        run_op(8'h80, 25'h1000000, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
